// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: the pipeline MEM stage owns the port by default, and a
// debug/loader requester gets single-cycle slots when the pipeline is idle or starved.
module dmem_port_arbiter #(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  // pipeline MEM stage
  input  logic              p_req,
  input  logic              p_we,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic [DATA_W-1:0] p_rdata,
  output logic              p_stall,
  // debug / loader requester
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  // data memory
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    StPOwn   = 2'd0,
    StDGrant = 2'd1,
    StDResp  = 2'd2
  } state_e;

  localparam logic [7:0] Limit = 8'(STARVE_LIMIT);

  state_e     state_q;
  logic [7:0] wait_cnt_q;
  logic       d_grant;
  logic       d_win;

  assign d_grant = (state_q == StDGrant);
  // Debug wins in P_OWN when the pipeline is idle or has starved it long enough.
  assign d_win   = d_req && (!p_req || (wait_cnt_q == Limit));

  always_comb begin
    mem_addr  = p_addr;
    mem_wdata = p_wdata;
    mem_we    = p_req & p_we;
    if (d_grant) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_we    = d_we;
    end
  end

  assign p_rdata = mem_rdata;
  assign p_stall = d_grant & p_req;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StPOwn;
      wait_cnt_q <= 8'd0;
      d_ack      <= 1'b0;
      d_rdata    <= '0;
    end else begin
      unique case (state_q)
        StPOwn: begin
          d_ack <= 1'b0;
          if (d_win) begin
            state_q    <= StDGrant;
            wait_cnt_q <= 8'd0;
          end else if (d_req) begin
            if (wait_cnt_q != Limit) wait_cnt_q <= wait_cnt_q + 8'd1;
          end else begin
            wait_cnt_q <= 8'd0;
          end
        end
        StDGrant: begin
          // Captured on writes as well; the requester ignores it then.
          d_rdata <= mem_rdata;
          d_ack   <= 1'b1;
          state_q <= StDResp;
        end
        StDResp: begin
          // d_req is ignored here so the requester has time to drop it.
          d_ack   <= 1'b0;
          state_q <= StPOwn;
        end
        default: begin
          d_ack   <= 1'b0;
          state_q <= StPOwn;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural data memory behind the port.
module tb_dmem_port_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;

  logic          clk;
  logic          rst;
  logic          p_req, p_we;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata, p_rdata;
  logic          p_stall;
  logic          d_req, d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  dmem_port_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .STARVE_LIMIT(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .p_req    (p_req),
    .p_we     (p_we),
    .p_addr   (p_addr),
    .p_wdata  (p_wdata),
    .p_rdata  (p_rdata),
    .p_stall  (p_stall),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ack    (d_ack),
    .d_rdata  (d_rdata),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  logic [DW-1:0] mem [256];
  int            wr_count = 0;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr_count      <= wr_count + 1;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int         pcycles;
  int         wr_base;
  logic [7:0] grant_vec, ack_vec;
  logic       ack_seen;

  initial begin
    rst = 1'b0; p_req = 1'b1; p_we = 1'b0; p_addr = 8'h33; p_wdata = '0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h10; d_wdata = '0;
    tick();
    tick();
    check("rst_d_ack", 32'(d_ack), 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_p_stall", 32'(p_stall), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'h33);

    // Idle-pipeline debug write
    rst = 1'b1; p_req = 1'b0; d_req = 1'b0;
    tick();
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h10; d_wdata = 32'hDEADBEEF;
    #1;
    check("dw_req_cycle_we", 32'(mem_we), 32'd0);
    tick();
    check("dw_grant_we", 32'(mem_we), 32'd1);
    check("dw_grant_addr", 32'(mem_addr), 32'h10);
    check("dw_grant_wdata", mem_wdata, 32'hDEADBEEF);
    check("dw_grant_ack", 32'(d_ack), 32'd0);
    tick();
    check("dw_ack", 32'(d_ack), 32'd1);
    check("dw_mem", mem[8'h10], 32'hDEADBEEF);
    d_req = 1'b0; d_we = 1'b0;
    tick();
    check("dw_ack_drop", 32'(d_ack), 32'd0);

    // Debug read back
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h10;
    tick();
    check("dr_grant_we", 32'(mem_we), 32'd0);
    tick();
    check("dr_ack", 32'(d_ack), 32'd1);
    check("dr_rdata", d_rdata, 32'hDEADBEEF);
    d_req = 1'b0;
    tick();

    // Starvation: pipeline busy every cycle
    p_req = 1'b1; p_we = 1'b0; p_addr = 8'h40; d_req = 1'b1; d_addr = 8'h10;
    pcycles = 0;
    #1;
    for (int i = 0; i < 30; i++) begin
      if (p_stall) break;
      pcycles++;
      tick();
    end
    check("starve_p_cycles", 32'(pcycles), 32'd9);
    check("starve_stall", 32'(p_stall), 32'd1);
    check("starve_grant_addr", 32'(mem_addr), 32'h10);
    tick();
    check("starve_ack", 32'(d_ack), 32'd1);
    check("starve_resume_stall", 32'(p_stall), 32'd0);
    check("starve_resume_addr", 32'(mem_addr), 32'h40);
    d_req = 1'b0;
    tick();

    // Dropping d_req while blocked must clear the starvation count
    p_req = 1'b1; d_req = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    d_req = 1'b0;
    tick();
    d_req = 1'b1;
    pcycles = 0;
    #1;
    for (int i = 0; i < 30; i++) begin
      if (p_stall) break;
      pcycles++;
      tick();
    end
    check("drop_restart_cycles", 32'(pcycles), 32'd9);
    tick();
    d_req = 1'b0; p_req = 1'b0;
    tick();

    // Pipeline store racing a pending debug read of the same word
    wr_base = wr_count;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20;
    p_req = 1'b1; p_we = 1'b1; p_addr = 8'h20; p_wdata = 32'hA5A5A5A5;
    #1;
    check("race_p_we", 32'(mem_we), 32'd1);
    tick();
    p_req = 1'b0; p_we = 1'b0;
    tick();
    check("race_grant_we", 32'(mem_we), 32'd0);
    tick();
    check("race_ack", 32'(d_ack), 32'd1);
    check("race_rdata", d_rdata, 32'hA5A5A5A5);
    check("race_writes", 32'(wr_count - wr_base), 32'd1);
    d_req = 1'b0;
    tick();
    tick();

    // Back-to-back debug with d_req held high
    p_req = 1'b0; p_addr = 8'h55; d_req = 1'b1; d_we = 1'b0; d_addr = 8'h10;
    grant_vec = '0; ack_vec = '0;
    #1;
    for (int i = 0; i < 8; i++) begin
      grant_vec[i] = (mem_addr == 8'h10);
      ack_vec[i]   = d_ack;
      tick();
    end
    check("b2b_grants", 32'(grant_vec), 32'h92);
    check("b2b_acks", 32'(ack_vec), 32'h24);
    d_req = 1'b0;
    tick();
    tick();
    check("b2b_idle_ack", 32'(d_ack), 32'd0);

    // Reset while in D_GRANT abandons the access
    d_req = 1'b1; d_we = 1'b0; p_req = 1'b0;
    tick();
    rst = 1'b0; p_req = 1'b1;
    #1;
    check("rg_stall_before", 32'(p_stall), 32'd1);
    tick();
    check("rg_ack", 32'(d_ack), 32'd0);
    check("rg_stall", 32'(p_stall), 32'd0);
    check("rg_mem_addr", 32'(mem_addr), 32'h55);
    rst = 1'b1; d_req = 1'b0; p_req = 1'b0;
    ack_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ack_seen = ack_seen | d_ack;
      tick();
    end
    check("rg_no_ack", 32'(ack_seen), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
